// File: rtl/rx_line_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_line_checker_if
// Purpose  : Bundles the UART receive handshake and the per-line result /
//            statistics outputs of rx_line_checker.
// Ports    : RxFull, RxData          - byte offered by the UART receiver
//            RxAck                   - byte consumed, held until RxFull falls
//            LineDone                - one-cycle pulse per finished line
//            LineMatch, LineErr      - result / abort cause of the last line
//            ByteCount, LastByte     - progress of current or last line
//            GoodLines, BadLines     - saturating line statistics
//            Modport master: UART receiver side; modport slave: the checker.
// Revision : 1.0  initial release
// ============================================================================
interface rx_line_checker_if;
   logic        RxFull;
   logic [7:0]  RxData;
   logic        RxAck;
   logic        LineDone;
   logic        LineMatch;
   logic [1:0]  LineErr;
   logic [7:0]  ByteCount;
   logic [7:0]  LastByte;
   logic [15:0] GoodLines;
   logic [15:0] BadLines;

   modport master (
      output RxFull, RxData,
      input  RxAck, LineDone, LineMatch, LineErr, ByteCount, LastByte,
             GoodLines, BadLines
   );

   modport slave (
      input  RxFull, RxData,
      output RxAck, LineDone, LineMatch, LineErr, ByteCount, LastByte,
             GoodLines, BadLines
   );
endinterface
`default_nettype wire

// File: rtl/rx_line_checker.sv
`default_nettype none
// ============================================================================
// Module   : rx_line_checker
// Purpose  : Drains bytes from a UART receiver with a level handshake,
//            assembles newline-terminated lines, compares each line with the
//            fixed "Hello World!\n" message and keeps good/bad line counters.
//            Lines with no newline are aborted at MAX_LEN bytes (overflow) or
//            after TIMEOUT_CYCLES idle clocks (timeout).
// Ports    : Clock    - system clock, rising edge
//            Reset_n  - asynchronous, active-low reset
//            bus      - rx_line_checker_if.slave (handshake and results)
// Revision : 1.0  initial release
// ============================================================================
module rx_line_checker #(
   parameter int MSG_LEN        = 13,
   parameter int MAX_LEN        = 32,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input wire               Clock,
   input wire               Reset_n,
   rx_line_checker_if.slave bus
);

   localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]       NL        = 8'h0A;
   localparam logic [7:0]       MSG_LEN_B = 8'(MSG_LEN);
   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_ACK   = 2'd1,
      RX_CHECK = 2'd2
   } state_t;

   state_t           state_q;
   logic             line_active_q;   // at least one byte of the line accepted
   logic             mismatch_q;
   logic [TMO_W-1:0] tmo_q;
   logic             rxack_q;
   logic             done_q;
   logic             match_q;
   logic [1:0]       err_q;
   logic [7:0]       count_q;
   logic [7:0]       last_q;
   logic [15:0]      good_q;
   logic [15:0]      bad_q;

   logic [7:0]       base_d;
   logic [7:0]       count_d;
   logic             byte_bad_d;

   function automatic logic [7:0] rom_byte(input logic [7:0] idx);
      case (idx)
         8'd0:    rom_byte = 8'd72;
         8'd1:    rom_byte = 8'd101;
         8'd2:    rom_byte = 8'd108;
         8'd3:    rom_byte = 8'd108;
         8'd4:    rom_byte = 8'd111;
         8'd5:    rom_byte = 8'd32;
         8'd6:    rom_byte = 8'd87;
         8'd7:    rom_byte = 8'd111;
         8'd8:    rom_byte = 8'd114;
         8'd9:    rom_byte = 8'd108;
         8'd10:   rom_byte = 8'd100;
         8'd11:   rom_byte = 8'd33;
         8'd12:   rom_byte = 8'd10;
         default: rom_byte = 8'd0;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ByteCount stays readable after a line ends, so the first byte of a new
   // line counts from zero rather than from the stale value.
   always_comb begin
      base_d     = line_active_q ? count_q : 8'd0;
      count_d    = base_d + 8'd1;
      byte_bad_d = (base_d >= MSG_LEN_B) ? 1'b1 : (bus.RxData != rom_byte(base_d));
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= RX_IDLE;
         line_active_q <= 1'b0;
         mismatch_q    <= 1'b0;
         tmo_q         <= '0;
         rxack_q       <= 1'b0;
         done_q        <= 1'b0;
         match_q       <= 1'b0;
         err_q         <= 2'd0;
         count_q       <= 8'd0;
         last_q        <= 8'd0;
         good_q        <= 16'd0;
         bad_q         <= 16'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               // An arriving byte takes priority over a timeout in the same cycle.
               if (bus.RxFull) begin
                  last_q        <= bus.RxData;
                  mismatch_q    <= mismatch_q | byte_bad_d;
                  count_q       <= count_d;
                  line_active_q <= 1'b1;
                  tmo_q         <= '0;
                  rxack_q       <= 1'b1;
                  state_q       <= RX_ACK;
               end else if (line_active_q) begin
                  if (tmo_q == TMO_LAST) begin
                     done_q        <= 1'b1;
                     match_q       <= 1'b0;
                     err_q         <= 2'd2;
                     bad_q         <= sat_inc(bad_q);
                     mismatch_q    <= 1'b0;
                     line_active_q <= 1'b0;
                     tmo_q         <= '0;
                  end else begin
                     tmo_q <= tmo_q + TMO_ONE;
                  end
               end
            end
            RX_ACK: begin
               if (!bus.RxFull) begin
                  rxack_q <= 1'b0;
                  state_q <= (last_q == NL || count_q == MAX_LEN_B) ? RX_CHECK : RX_IDLE;
               end
            end
            RX_CHECK: begin
               match_q <= !mismatch_q && count_q == MSG_LEN_B && last_q == NL;
               err_q   <= (count_q == MAX_LEN_B && last_q != NL) ? 2'd1 : 2'd0;
               done_q  <= 1'b1;
               if (!mismatch_q && count_q == MSG_LEN_B && last_q == NL) begin
                  good_q <= sat_inc(good_q);
               end else begin
                  bad_q  <= sat_inc(bad_q);
               end
               mismatch_q    <= 1'b0;
               line_active_q <= 1'b0;
               tmo_q         <= '0;
               state_q       <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign bus.RxAck     = rxack_q;
   assign bus.LineDone  = done_q;
   assign bus.LineMatch = match_q;
   assign bus.LineErr   = err_q;
   assign bus.ByteCount = count_q;
   assign bus.LastByte  = last_q;
   assign bus.GoodLines = good_q;
   assign bus.BadLines  = bad_q;

endmodule
`default_nettype wire

// File: doc/rx_line_checker.md
Name: rx_line_checker

Overview:
- Receive-side consumer for the UART link, the counterpart of the transmit driver that sends "Hello World!\n" (13 bytes) once per period.
- Drains bytes from the UART receiver using a level handshake (RxFull / RxAck) and assembles one line per newline (8'h0A).
- Compares each line against the fixed expected message and reports a per-line pass/fail result.
- Keeps cumulative good/bad line counters for board LEDs/7-seg and for the loopback bench.

Parameters:
MSG_LEN, 13, length in bytes of the expected message, including the terminating 8'h0A
MAX_LEN, 32, byte count at which a line with no newline is aborted as overflow; must be greater than MSG_LEN
TIMEOUT_CYCLES, 1000, idle clocks allowed between bytes of a started line before it is aborted

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
RxFull  input  1  UART receiver holds a valid byte on RxData while this is high
RxData  input  8  received byte, stable while RxFull is high
RxAck  output  1  byte consumed; held high until RxFull falls
LineDone  output  1  one-cycle pulse when a line is complete or aborted
LineMatch  output  1  result of the last line, valid from the LineDone pulse until the next one
LineErr  output  2  abort cause of the last line: 0 none, 1 overflow, 2 timeout
ByteCount  output  8  bytes accepted in the current or last line
LastByte  output  8  most recently accepted byte
GoodLines  output  16  saturating count of matching lines
BadLines  output  16  saturating count of mismatching or aborted lines

Behaviour:
- Reset (Reset_n low, asynchronous): all outputs are 0, state is RX_IDLE, mismatch flag is clear, timeout counter is 0. Reset asserted mid-line discards the partial line; no LineDone is generated.
- Expected message ROM is a constant inside the block: 72,101,108,108,111,32,87,111,114,108,100,33,10.
- RX_IDLE:
  - When RxFull=1, latch RxData into LastByte.
  - Compare RxData with rom[ByteCount] and set the sticky mismatch flag on a difference, or when ByteCount >= MSG_LEN.
  - Increment ByteCount, then go to RX_ACK.
  - ByteCount is cleared when the first byte of a new line is accepted, not at LineDone, so it stays readable after a line ends.
- RX_ACK:
  - Drive RxAck=1 (registered, so it rises on the cycle after the accept).
  - Stay in RX_ACK while RxFull=1. RxFull may stay high for any number of cycles; the byte is counted exactly once.
  - When RxFull=0, drop RxAck on the next edge and go to:
    - RX_CHECK if LastByte==8'h0A or ByteCount==MAX_LEN;
    - otherwise back to RX_IDLE.
- RX_CHECK (one cycle):
  - LineMatch = !mismatch && ByteCount==MSG_LEN && LastByte==8'h0A.
  - LineErr = 1 if ByteCount==MAX_LEN and LastByte!=8'h0A; otherwise 0.
  - Pulse LineDone; increment GoodLines or BadLines (saturating at 16'hFFFF); clear the mismatch flag; go to RX_IDLE.
- Timeout:
  - Counts only in RX_IDLE, and only after at least one byte of the line has been accepted.
  - Reset to 0 on every accept.
  - On reaching TIMEOUT_CYCLES: LineDone pulse, LineMatch=0, LineErr=2, BadLines increments, line state is cleared.
- Latency: accept to RxAck rise is 1 cycle; RxFull fall to LineDone for a newline byte is 2 cycles.
- Simultaneous events:
  - If a timeout would fire in the same cycle RxFull rises, the byte wins and the timeout counter clears.
  - An empty line (0x0A as the first byte) is a mismatch with ByteCount=1.
- Width rules: ByteCount never exceeds MAX_LEN. ROM indexing is guarded for ByteCount >= MSG_LEN, so there is no out-of-range read.

Test Plan:
- Send "Hello World!\n" with the UART model raising RxFull and dropping it 1 cycle after RxAck -> exactly 13 acks, LineDone once, LineMatch=1, LineErr=0, ByteCount=13, GoodLines=1.
- Send "Hello Wprld!\n" -> LineMatch=0, LineErr=0, BadLines=1; then send the correct line -> GoodLines=1 (mismatch flag cleared between lines).
- Send "Hi\n" then 40 bytes of 8'h41 with no newline -> first line: mismatch with ByteCount=3; second line: abort at byte 32 with LineErr=1, BadLines=2, remaining 8 bytes begin a new line.
- Send "Hel", then idle 1000 cycles -> LineDone on the timeout cycle, LineErr=2, ByteCount=3; 5000 cycles idle before any byte -> no LineDone.
- Hold RxFull high 50 cycles for one byte -> one accept, RxAck high until RxFull falls, ByteCount increments by 1.
- Assert Reset_n low between bytes 6 and 7 of a valid line -> all outputs 0 immediately (asynchronous), no LineDone; the following full line passes with GoodLines=1.
